softmax_shift: RTL and testbench

Row-normalisation stage for the attention head's softmax path. It accepts one row of `ROW_LEN` signed scores and buffers the row while tracking its running maximum. It then streams each buffered score minus the row maximum, so every output is ≤ 0 and ready for the exponent stage. It is the consumer side of the row-max computation: the same max is computed internally and applied to the stored row.

---
 rtl/softmax_shift.sv | 84 ++++++++
 tb/tb_softmax_shift.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/softmax_shift.sv
// Softmax row-normalisation: buffers one row of signed scores and tracks its max,
// then streams each score minus the row max, saturated, so every output is <= 0.
module softmax_shift #(
  parameter int D_W     = 32,
  parameter int ROW_LEN = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [D_W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D_W-1:0] out_data,
  output logic           out_last,
  output logic [D_W-1:0] row_max
);

  localparam int PW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [PW-1:0] LAST = PW'(ROW_LEN - 1);

  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_t;

  state_t state, state_nx;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [ROW_LEN-1:0][D_W-1:0] mem;
  logic in_fire, out_fire, take_max;
  logic [D_W-1:0] cur, sat;
  logic [D_W:0] diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && wr_ptr == LAST) state_nx = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && rd_ptr == LAST) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // First element of a row seeds the max so the reset value never competes.
  assign take_max = (wr_ptr == '0) || ($signed(in_data) >= $signed(row_max));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      row_max <= '0;
    end else begin
      if (in_fire) begin
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        if (take_max) row_max <= in_data;
      end
      if (out_fire) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem[wr_ptr] <= in_data;
  end

  // Difference never goes positive, so a sign/overflow split means underflow.
  assign cur  = mem[rd_ptr];
  assign diff = {cur[D_W-1], cur} - {row_max[D_W-1], row_max};
  assign sat  = (diff[D_W] != diff[D_W-1]) ? {1'b1, {(D_W-1){1'b0}}} : diff[D_W-1:0];

  assign out_data = out_valid ? sat : '0;
  assign out_last = out_valid && (rd_ptr == LAST);

endmodule

// File: tb/tb_softmax_shift.sv
// Directed bench: a 32-bit and an 8-bit instance (ROW_LEN=4) share the same stimulus.
module tb_softmax_shift;

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready;
  logic signed [31:0] in_data;
  logic in_ready, out_valid, out_last;
  logic signed [31:0] out_data, row_max;
  logic i8_ready, o8_valid, o8_last;
  logic signed [7:0] o8_data, m8;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  softmax_shift #(.D_W(32), .ROW_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .row_max(row_max));

  softmax_shift #(.D_W(8), .ROW_LEN(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(i8_ready),
    .in_data(in_data[7:0]), .out_valid(o8_valid), .out_ready(out_ready),
    .out_data(o8_data), .out_last(o8_last), .row_max(m8));

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    fails++;
    $error("FAIL %s: timed out waiting on DUT", tag);
  endtask

  task automatic send(input logic signed [31:0] v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) timeout("send");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic recv(input logic signed [31:0] exp, input logic exp_last, input string tag);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) timeout(tag);
    chk(tag, out_data, exp);
    chk({tag, "_last"}, out_last, exp_last);
    @(posedge clk); #1;
  endtask

  // Drives one row with optional random input gaps, checks it against a longint model.
  task automatic run_row(input logic signed [31:0] r [4], input bit gaps, input string tag);
    logic signed [31:0] mx;
    longint d;
    int idx = 0, k = 0, cyc = 0;
    bit acc, seen_drain = 0;
    mx = r[0];
    for (int i = 1; i < 4; i++) if (r[i] >= mx) mx = r[i];
    out_ready = 1'b1;
    while (!(seen_drain && in_ready) && cyc < 200) begin
      in_valid = (idx < 4) && (!gaps || ($urandom_range(0, 1) == 1));
      in_data  = (idx < 4) ? r[idx] : 32'sd0;
      if (out_valid) begin
        d = longint'(r[k]) - longint'(mx);
        if (d < -64'sd2147483648) d = -64'sd2147483648;
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_last"}, out_last, (k == 3));
        chk({tag, "_max"}, row_max, mx);
        k++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
      if (!in_ready) seen_drain = 1;
    end
    in_valid = 1'b0;
    if (cyc >= 200) timeout(tag);
    chk({tag, "_nout"}, k, 4);
    if (!gaps) chk({tag, "_cycles"}, cyc, 8);
  endtask

  logic signed [31:0] rr [4];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_row_max", row_max, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // 1: basic row
    send(3); send(-5); send(7); send(7);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_in_ready", in_ready, 0);
    chk("t1_max", row_max, 7);
    recv(-4, 0, "t1_o0"); recv(-12, 0, "t1_o1");
    recv(0, 0, "t1_o2");  recv(0, 1, "t1_o3");
    chk("t1_in_ready_back", in_ready, 1);
    chk("t1_out_valid_off", out_valid, 0);

    // 2: all negative, max must come from first element
    send(-1); send(-2); send(-3); send(-4);
    chk("t2_max", row_max, -1);
    recv(0, 0, "t2_o0"); recv(-1, 0, "t2_o1");
    recv(-2, 0, "t2_o2"); recv(-3, 1, "t2_o3");

    // 3: 8-bit saturation (32-bit instance sees the unsaturated values)
    send(-128); send(127); send(0); send(0);
    chk("t3_max8", m8, 127);
    chk("t3_d8_0", o8_data, -128);
    recv(-255, 0, "t3_d32_0");
    chk("t3_d8_1", o8_data, 0);
    recv(0, 0, "t3_d32_1");
    chk("t3_d8_2", o8_data, -127);
    recv(-127, 0, "t3_d32_2");
    chk("t3_d8_3", o8_data, -127);
    chk("t3_last8", o8_last, 1);
    recv(-127, 1, "t3_d32_3");

    // 4: output stall with junk input driven
    send(1); send(2); send(3); send(4);
    recv(-3, 0, "t4_o0");
    out_ready = 1'b0; in_valid = 1'b1; in_data = 99;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t4_hold_data", out_data, -2);
      chk("t4_hold_ready", in_ready, 0);
      chk("t4_hold_max", row_max, 4);
    end
    in_valid = 1'b0;
    recv(-2, 0, "t4_o1"); recv(-1, 0, "t4_o2"); recv(0, 1, "t4_o3");

    // 5: async reset mid-drain
    send(10); send(20); send(30); send(40);
    recv(-30, 0, "t5_o0"); recv(-20, 0, "t5_o1");
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_last", out_last, 0);
    chk("t5_rst_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_in_ready", in_ready, 1);
    send(-8); send(-6); send(-7); send(-9);
    chk("t5_max", row_max, -6);
    recv(-2, 0, "t5_n0"); recv(0, 0, "t5_n1");
    recv(-1, 0, "t5_n2"); recv(-3, 1, "t5_n3");

    // 6: back-to-back rows, model-checked
    for (int i = 0; i < 4; i++) rr[i] = $urandom();
    run_row(rr, 1'b0, "t6_r0");
    rr[0] = 32'sh8000_0000; rr[1] = 32'sh7fff_ffff; rr[2] = -32'sd5; rr[3] = 32'sd17;
    run_row(rr, 1'b1, "t6_r1");
    for (int i = 0; i < 4; i++) rr[i] = $urandom();
    run_row(rr, 1'b1, "t6_r2");
    for (int i = 0; i < 4; i++) rr[i] = $urandom_range(0, 1000) - 500;
    run_row(rr, 1'b0, "t6_r3");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
